// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants and FIFO operation encoding used by the UART receive path.
package uart_rx_fifo_pkg;

  // Default byte width and depth (log2) shared by uart_rx and the receive FIFO.
  localparam int UART_DATA_W = 8;
  localparam int UART_ADDR_W = 4;

  // Per-cycle FIFO operation, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO: synchronous write, address-indexed read, no reset.
module uart_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Write the accepted byte into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port is purely address-indexed; the caller registers the result.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and its consumer: pointer, occupancy and
// overflow control around a uart_fifo_mem storage array, with a registered pop port.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = UART_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] mem_rdata_s;
  logic              push_s, pop_s, drop_s;
  fifo_op_e          op_s;

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata_s)
  );

  // Accept logic and next-state computation; a pop frees a slot so a push into a full FIFO still lands.
  always_comb begin
    pop_s      = rd_en && (count_q != CNT_ZERO);
    push_s     = rx_done && ((count_q != DEPTH) || pop_s);
    drop_s     = rx_done && !push_s;
    op_s       = fifo_op_e'({push_s, pop_s});
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q;

    case (op_s)
      OP_PUSH: count_d = count_q + CNT_ONE;
      OP_POP:  count_d = count_q - CNT_ONE;
      OP_BOTH: count_d = count_q;
      OP_IDLE: count_d = count_q;
      default: count_d = count_q;
    endcase

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      rd_data_d  = mem_rdata_s;
      rd_valid_d = 1'b1;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
    end

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers; reset discards stored bytes and any in-flight pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= {ADDR_W{1'b0}};
      rd_ptr_q   <= {ADDR_W{1'b0}};
      count_q    <= CNT_ZERO;
      rd_data_q  <= {DATA_W{1'b0}};
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign overflow = overflow_q;
  assign count    = count_q;
  assign empty    = (count_q == CNT_ZERO);
  assign full     = (count_q == DEPTH);

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning byte width of each stored entry.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning log2 of depth (default 16 entries).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port rx_done  input  1  one-cycle push strobe from the UART receiver.
REQ-006 SHALL have port rx_data  input  DATA_W  received byte, valid in the cycle rx_done=1.
REQ-007 SHALL have port rd_en  input  1  pop request from the consumer.
REQ-008 SHALL have port rd_data  output  DATA_W  registered popped byte.
REQ-009 SHALL have port rd_valid  output  1  one-cycle pulse; rd_data valid in that cycle.
REQ-010 SHALL have port empty  output  1  count==0.
REQ-011 SHALL have port full  output  1  count==2^ADDR_W.
REQ-012 SHALL have port count  output  ADDR_W+1  current occupancy.
REQ-013 SHALL have port overflow  output  1  sticky flag: a byte was dropped.
REQ-014 SHALL have port clr_ovf  input  1  one-cycle clear of overflow.

Function
REQ-015 Push accepted when rx_done=1 and (full=0 or accepted pop in same cycle); byte written at wr_ptr, wr_ptr increments.
REQ-016 Pop accepted when rd_en=1 and empty=0; entry at rd_ptr loaded into rd_data at the next edge, rd_valid=1 for exactly that one cycle, rd_ptr increments.
REQ-017 Read latency: rd_data/rd_valid appear 1 cycle after the accepted rd_en edge.
REQ-018 rd_en while empty ignored: no pointer change, rd_valid=0, rd_data holds.
REQ-019 rd_data holds last popped value when no pop is accepted.
REQ-020 Pointers ADDR_W bits, wrap modulo 2^ADDR_W; count tracked separately (ADDR_W+1 bits), never exceeds 2^ADDR_W or goes below 0.
REQ-021 Simultaneous accepted push and pop: count unchanged, both pointers advance.
REQ-022 Full with simultaneous push and pop: both accepted, no overflow.
REQ-023 Empty with simultaneous push and pop: push accepted, pop ignored, count becomes 1.
REQ-024 Push while full without pop: byte dropped, memory/pointers unchanged, overflow set next cycle.
REQ-025 overflow stays 1 until clr_ovf=1; if clr_ovf and a drop occur in the same cycle, overflow remains 1 (set wins).
REQ-026 empty, full, count registered/derived from registered count; update the cycle after the causing event.
REQ-027 Data order strictly first-in first-out; no byte duplicated or reordered.

Reset
REQ-028 reset=0 SHALL immediately clear wr_ptr, rd_ptr, count, rd_data, rd_valid, overflow to 0; empty=1, full=0.
REQ-029 Memory contents need not be reset; entries unreadable until rewritten.
REQ-030 Reset mid-operation discards all stored bytes and any in-flight pop; no rd_valid pulse after deassertion until a new pop is accepted.

Structure
REQ-031 Default DATA_W and ADDR_W SHALL live in the shared UART constants header, used by uart_rx and this block.
REQ-032 Storage SHALL be one sub-module, uart_fifo_mem: synchronous write, address-indexed read, no reset; pointer/count/flag control stays in uart_rx_fifo.

Verification
REQ-033 Reset, push 0x41, 0x42, 0x43 -> count=3; three rd_en -> rd_data 0x41,0x42,0x43 each with one rd_valid pulse, then empty=1.
REQ-034 Push 16 bytes 0x00..0x0F -> full=1, count=16; 17th push 0xFF -> dropped, overflow=1; pop all -> 0x00..0x0F, no 0xFF.
REQ-035 Full, rx_done and rd_en same cycle with 0x55 -> count stays 16, overflow=0; 0x55 is the last byte popped.
REQ-036 Empty, rx_done 0xA5 with rd_en same cycle -> rd_valid=0 that cycle, count=1; next pop returns 0xA5.
REQ-037 overflow=1, clr_ovf and a dropped push same cycle -> overflow stays 1; clr_ovf alone next cycle -> overflow=0.
REQ-038 Five bytes stored, reset pulsed low mid-pop -> empty=1, count=0, rd_valid=0, overflow=0; following push/pop of 0x3C returns 0x3C.
